// File: rtl/bally_pkg.sv
// Shared types and constants for the Bally CPU-side input ports.
// Optional feature macro used by the importing modules: BALLY_POT_EN (paddle reads).
package bally_pkg;

    // Access sequencer states for the keypad port.
    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StDone
    } state_e;

    // Default IO base of the keypad column block (8 consecutive ports).
    localparam logic [7:0] KEYPAD_PORT_BASE = 8'h10;

    // Paddle ports sit at base + C..F, one per pot.
    localparam logic [3:0] POT_OFFSET = 4'hC;

    // One-hot column drive for a 3-bit column index.
    function automatic logic [7:0] col_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/bally_port_decode.sv
// Combinational address decode for the keypad port.
// Key hits cover PORT_BASE[7:3] + 0..7; pot hits (BALLY_POT_EN only) cover base + C..F.
module bally_port_decode
    import bally_pkg::*;
#(
    parameter logic [7:0] PORT_BASE = KEYPAD_PORT_BASE
) (
    input  logic       io_rd,
    input  logic [7:0] io_addr,
    output logic       key_hit,
    output logic       pot_hit,
    output logic [2:0] col_idx,
    output logic [1:0] pot_idx
);

`ifdef BALLY_POT_EN
    // The pot window is anchored to the aligned column block so it never straddles it.
    localparam logic [7:0] POT_BASE = {PORT_BASE[7:3], 3'b000} + {4'h0, POT_OFFSET};
`endif

    // Address compare and index extraction.
    always_comb begin
        key_hit = io_rd && (io_addr[7:3] == PORT_BASE[7:3]);
`ifdef BALLY_POT_EN
        pot_hit = io_rd && (io_addr[7:2] == POT_BASE[7:2]);
`else
        pot_hit = 1'b0;
`endif
        col_idx = io_addr[2:0];
        pot_idx = io_addr[1:0];
    end

endmodule

// File: rtl/bally_keypad_port.sv
// CPU-side keypad/hand-controller port: decodes IO reads, drives a one-hot column,
// waits for the matrix rows to settle, captures them and acks the CPU.
// Optional macro BALLY_POT_EN adds a fast paddle read path at PORT_BASE + C..F.
module bally_keypad_port
    import bally_pkg::*;
#(
    parameter logic [7:0]  PORT_BASE     = KEYPAD_PORT_BASE,
    // Cycles col_select is held before capture; legal range 1..15.
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] io_addr,
    input  logic       io_rd,
    output logic [7:0] io_data,
    output logic       io_ack,
    output logic       busy,
    output logic [7:0] col_select,
    input  logic [7:0] row_data,
    input  logic [7:0] pot_a,
    input  logic [7:0] pot_b,
    input  logic [7:0] pot_c,
    input  logic [7:0] pot_d
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic       key_hit;
    logic       pot_hit;
    logic [2:0] col_idx;
    logic [1:0] pot_idx;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] col_select_q, col_select_d;
    logic [7:0] io_data_q, io_data_d;
    logic       io_ack_q, io_ack_d;
    logic       busy_q, busy_d;
    logic       pot_sel_q, pot_sel_d;
    logic [1:0] pot_idx_q, pot_idx_d;
    logic [7:0] pot_value;

    bally_port_decode #(
        .PORT_BASE (PORT_BASE)
    ) u_decode (
        .io_rd   (io_rd),
        .io_addr (io_addr),
        .key_hit (key_hit),
        .pot_hit (pot_hit),
        .col_idx (col_idx),
        .pot_idx (pot_idx)
    );

    // Paddle source for the current access; pot_sel_q never sets without BALLY_POT_EN.
    always_comb begin
        unique case (pot_idx_q)
            2'd0:    pot_value = pot_a;
            2'd1:    pot_value = pot_b;
            2'd2:    pot_value = pot_c;
            default: pot_value = pot_d;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests outside StIdle are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (key_hit) begin
                    state_d = StSettle;
                end else if (pot_hit) begin
                    state_d = StCapture;
                end
            end
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output and datapath next values; everything holds unless the state acts on it.
    always_comb begin
        cnt_d        = cnt_q;
        col_select_d = col_select_q;
        io_data_d    = io_data_q;
        io_ack_d     = io_ack_q;
        busy_d       = busy_q;
        pot_sel_d    = pot_sel_q;
        pot_idx_d    = pot_idx_q;
        unique case (state_q)
            StIdle: begin
                if (key_hit) begin
                    col_select_d = col_onehot(col_idx);
                    cnt_d        = SETTLE_INIT;
                    busy_d       = 1'b1;
                    pot_sel_d    = 1'b0;
                end else if (pot_hit) begin
                    busy_d    = 1'b1;
                    pot_sel_d = 1'b1;
                    pot_idx_d = pot_idx;
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                io_data_d    = pot_sel_q ? pot_value : row_data;
                io_ack_d     = 1'b1;
                col_select_d = 8'h00;
            end
            StDone: begin
                io_ack_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                col_select_d = 8'h00;
                io_ack_d     = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // Registered outputs, counter and access context.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            col_select_q <= 8'h00;
            io_data_q    <= 8'h00;
            io_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            pot_sel_q    <= 1'b0;
            pot_idx_q    <= 2'd0;
        end else begin
            cnt_q        <= cnt_d;
            col_select_q <= col_select_d;
            io_data_q    <= io_data_d;
            io_ack_q     <= io_ack_d;
            busy_q       <= busy_d;
            pot_sel_q    <= pot_sel_d;
            pot_idx_q    <= pot_idx_d;
        end
    end

    assign io_data    = io_data_q;
    assign io_ack     = io_ack_q;
    assign busy       = busy_q;
    assign col_select = col_select_q;

endmodule

// File: tb/tb_bally_keypad_port.sv
// Scoreboard bench for bally_keypad_port: stimulus pushes expected acks (data and cycle),
// a negedge monitor pops and compares whenever io_ack is seen.
module tb_bally_keypad_port;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] io_addr;
    logic       io_rd;
    logic [7:0] io_data;
    logic       io_ack;
    logic       busy;
    logic [7:0] col_select;
    logic [7:0] row_data;
    logic [7:0] pot_a, pot_b, pot_c, pot_d;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];

    // Matrix model contents: row pattern returned for each selected column.
    logic [7:0] col_data [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h3C, 8'h5A, 8'h66, 8'h7E};
    logic       row_fixed_en;
    logic [7:0] row_fixed;

    bally_keypad_port dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .io_addr    (io_addr),
        .io_rd      (io_rd),
        .io_data    (io_data),
        .io_ack     (io_ack),
        .busy       (busy),
        .col_select (col_select),
        .row_data   (row_data),
        .pot_a      (pot_a),
        .pot_b      (pot_b),
        .pot_c      (pot_c),
        .pot_d      (pot_d)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [7:0] matrix_row(input logic [7:0] cs);
        if (row_fixed_en) return row_fixed;
        for (int k = 0; k < 8; k++) begin
            if (cs == (8'h01 << k)) return col_data[k];
        end
        return 8'h00;
    endfunction

    // Input matrix: rows registered one cycle after the column select.
    always @(posedge clk_sys or posedge reset) begin
        if (reset) row_data <= 8'h00;
        else       row_data <= matrix_row(col_select);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: column select shape every cycle, scoreboard pop on every ack.
    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset) begin
            check("col_select one-hot or zero", 32'($onehot0(col_select)), 32'd1);
            if (io_ack) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected io_ack: io_data %0h at cycle %0d, no ack expected",
                             io_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " io_data"}, 32'(io_data), 32'(e.data));
                    check({e.name, " ack cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    // Drive a one-cycle read at the current negedge; optionally expect an ack lat cycles later.
    task automatic issue(input logic [7:0] addr, input bit expect_ack, input logic [7:0] data,
                         input int lat, input string name);
        exp_t e;
        if (expect_ack) begin
            e.data = data;
            e.cyc  = cyc + lat;
            e.name = name;
            sb.push_back(e);
        end
        io_addr = addr;
        io_rd   = 1'b1;
        @(negedge clk_sys);
        io_rd   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, " busy released"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_busy, saw_col, saw_ack, saw_col01;

        reset = 1'b1;
        io_rd = 1'b0;
        io_addr = 8'h00;
        pot_a = 8'h3C;
        pot_b = 8'h5B;
        pot_c = 8'hA5;
        pot_d = 8'hC3;
        row_fixed_en = 1'b0;
        row_fixed = 8'h00;
        repeat (2) @(negedge clk_sys);
        check("reset io_data", 32'(io_data), 32'h00);
        check("reset io_ack", 32'(io_ack), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset col_select", 32'(col_select), 32'h00);
        reset = 1'b0;
        @(negedge clk_sys);

        // 1: column 2 read with stable rows, 4-cycle latency.
        row_fixed_en = 1'b1;
        row_fixed = 8'h05;
        issue(8'h12, 1'b1, 8'h05, 4, "t1 addr 12");
        check("t1 busy after accept", 32'(busy), 32'd1);
        check("t1 col_select +1", 32'(col_select), 32'h04);
        @(negedge clk_sys);
        check("t1 col_select +2", 32'(col_select), 32'h04);
        @(negedge clk_sys);
        check("t1 col_select +3", 32'(col_select), 32'h04);
        @(negedge clk_sys);
        check("t1 col_select in ack cycle", 32'(col_select), 32'h00);
        @(negedge clk_sys);
        check("t1 busy after done", 32'(busy), 32'd0);
        row_fixed_en = 1'b0;
        @(negedge clk_sys);

        // 2: address miss.
        issue(8'h20, 1'b0, 8'h00, 0, "t2");
        saw_busy = 0;
        saw_col = 0;
        saw_ack = 0;
        for (int i = 0; i < 10; i++) begin
            saw_busy |= busy;
            saw_col |= (col_select != 8'h00);
            saw_ack |= io_ack;
            @(negedge clk_sys);
        end
        check("t2 miss busy seen", 32'(saw_busy), 32'd0);
        check("t2 miss col_select seen", 32'(saw_col), 32'd0);
        check("t2 miss ack seen", 32'(saw_ack), 32'd0);

        // 3: second read while busy is dropped.
        begin
            exp_t e;
            e.data = 8'h7E;
            e.cyc = cyc + 4;
            e.name = "t3 addr 17";
            sb.push_back(e);
        end
        io_addr = 8'h17;
        io_rd = 1'b1;
        @(negedge clk_sys);
        io_addr = 8'h10;
        saw_col01 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            io_rd = 1'b0;
            saw_col01 |= (col_select == 8'h01);
        end
        check("t3 column 0 driven", 32'(saw_col01), 32'd0);
        wait_idle("t3");
        check("t3 pending acks", sb.size(), 0);

        // 4: reset during settle aborts the access.
        issue(8'h13, 1'b0, 8'h00, 0, "t4");
        @(negedge clk_sys);
        check("t4 settling col_select", 32'(col_select), 32'h08);
        #2 reset = 1'b1;
        #1;
        check("t4 col_select at reset", 32'(col_select), 32'h00);
        check("t4 busy at reset", 32'(busy), 32'd0);
        check("t4 io_data at reset", 32'(io_data), 32'h00);
        @(negedge clk_sys);
        reset = 1'b0;
        saw_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            saw_ack |= io_ack;
        end
        check("t4 ack after reset", 32'(saw_ack), 32'd0);

        // 5: back-to-back reads, second issued as busy falls.
        issue(8'h10, 1'b1, 8'h81, 4, "t5 addr 10");
        for (int i = 0; i < 10 && !io_ack; i++) @(negedge clk_sys);
        check("t5 first ack reached", 32'(io_ack), 32'd1);
        check("t5 col_select idle between", 32'(col_select), 32'h00);
        wait_idle("t5 first");
        issue(8'h11, 1'b1, 8'h42, 4, "t5 addr 11");
        check("t5 second col_select", 32'(col_select), 32'h02);
        wait_idle("t5 second");
        check("t5 pending acks", sb.size(), 0);
        @(negedge clk_sys);

        // 6: paddle read.
`ifdef BALLY_POT_EN
        issue(8'h1E, 1'b1, 8'hA5, 2, "t6 pot_c");
        check("t6 pot col_select", 32'(col_select), 32'h00);
        check("t6 pot busy", 32'(busy), 32'd1);
        wait_idle("t6 pot_c");
        @(negedge clk_sys);
        issue(8'h1C, 1'b1, 8'h3C, 2, "t6 pot_a");
        wait_idle("t6 pot_a");
`else
        issue(8'h1E, 1'b0, 8'h00, 0, "t6");
        saw_busy = 0;
        saw_ack = 0;
        for (int i = 0; i < 6; i++) begin
            saw_busy |= busy;
            saw_ack |= io_ack;
            @(negedge clk_sys);
        end
        check("t6 pot disabled busy", 32'(saw_busy), 32'd0);
        check("t6 pot disabled ack", 32'(saw_ack), 32'd0);
`endif

        repeat (3) @(negedge clk_sys);
        check("all expected acks seen", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
